// File: rtl/pdm_cic_decim.sv
// CIC decimator turning a 1-bit PDM stream into saturated signed PCM samples.
// Integrators run per pdm_en bit; a valid-driven comb pipe runs once per DECIM bits.
module pdm_cic_decim #(
  parameter int unsigned ORDER = 4,
  parameter int unsigned DECIM = 64,
  parameter int unsigned OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pdm_en,
  input  logic             pdm_din,
  output logic [OUT_W-1:0] pcm_out,
  output logic             pcm_valid,
  output logic             clip
);

  localparam int unsigned CNT_W = $clog2(DECIM);
  localparam int unsigned ACC_W = 2 + ORDER * CNT_W;
  localparam int unsigned SHIFT = ACC_W - 1 - OUT_W;
  localparam int unsigned Y_W   = OUT_W + 1;

  typedef logic signed [ACC_W-1:0] acc_t;

  acc_t             integ_q [ORDER];
  acc_t             integ_d [ORDER];
  acc_t             comb_q  [ORDER+1];
  acc_t             dly_q   [ORDER];
  logic [ORDER:0]   vld_q;
  logic [CNT_W-1:0] cnt_q;
  logic             tick_c;
  acc_t             step_c;
  acc_t             y_full_c;
  logic [Y_W-1:0]   y_c;
  logic             ovf_c;
  logic [OUT_W-1:0] sat_c;

  // Integrator next values, all from pre-edge state; wraps at ACC_W bits.
  always_comb begin
    step_c     = pdm_din ? acc_t'(1) : acc_t'({ACC_W{1'b1}});
    integ_d[0] = integ_q[0] + step_c;
    for (int k = 1; k < int'(ORDER); k++) begin
      integ_d[k] = integ_q[k] + integ_q[k-1];
    end
  end

  assign tick_c = pdm_en && (cnt_q == CNT_W'(DECIM - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      for (int k = 0; k < int'(ORDER); k++) begin
        integ_q[k] <= '0;
      end
    end else if (pdm_en) begin
      cnt_q <= cnt_q + CNT_W'(1);
      for (int k = 0; k < int'(ORDER); k++) begin
        integ_q[k] <= integ_d[k];
      end
    end
  end

  // Comb pipe: a valid bit walks through ORDER differentiator stages.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      for (int k = 0; k <= int'(ORDER); k++) begin
        comb_q[k] <= '0;
      end
      for (int k = 0; k < int'(ORDER); k++) begin
        dly_q[k] <= '0;
      end
    end else begin
      vld_q <= {vld_q[ORDER-1:0], tick_c};
      if (tick_c) begin
        comb_q[0] <= integ_d[ORDER-1];
      end
      for (int k = 1; k <= int'(ORDER); k++) begin
        if (vld_q[k-1]) begin
          comb_q[k]  <= comb_q[k-1] - dly_q[k-1];
          dly_q[k-1] <= comb_q[k-1];
        end
      end
    end
  end

  // Scale down and clamp; an overflow shows as the top two bits disagreeing.
  always_comb begin
    y_full_c = comb_q[ORDER] >>> SHIFT;
    y_c      = y_full_c[Y_W-1:0];
    ovf_c    = y_c[Y_W-1] ^ y_c[Y_W-2];
    sat_c    = ovf_c ? {y_c[Y_W-1], {(OUT_W-1){~y_c[Y_W-1]}}} : y_c[OUT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcm_out   <= '0;
      pcm_valid <= 1'b0;
      clip      <= 1'b0;
    end else begin
      pcm_valid <= vld_q[ORDER];
      clip      <= vld_q[ORDER] && ovf_c;
      if (vld_q[ORDER]) begin
        pcm_out <= sat_c;
      end
    end
  end

endmodule

// File: tb/tb_pdm_cic_decim.sv
// Scoreboard bench for pdm_cic_decim at default parameters (ORDER 4, DECIM 64, OUT_W 16).
`timescale 1ns/1ps
module tb_pdm_cic_decim;

  localparam int unsigned OUT_W = 16;
  localparam int unsigned ORDER = 4;
  localparam int unsigned DECIM = 64;

  typedef struct {
    logic             chk;
    logic [OUT_W-1:0] val;
    logic             clp;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             pdm_en = 1'b0;
  logic             pdm_din = 1'b0;
  logic [OUT_W-1:0] pcm_out;
  logic             pcm_valid;
  logic             clip;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   chk_spacing = 1'b0;

  pdm_cic_decim dut (
    .clk      (clk),
    .rst      (rst),
    .pdm_en   (pdm_en),
    .pdm_din  (pdm_din),
    .pcm_out  (pcm_out),
    .pcm_valid(pcm_valid),
    .clip     (clip)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic chk, input logic [OUT_W-1:0] val, input logic clp);
    exp_t e;
    e.chk = chk;
    e.val = val;
    e.clp = clp;
    sb.push_back(e);
  endtask

  // Monitor: pops one expectation per pcm_valid pulse.
  initial begin
    bit   prev_v = 1'b0;
    int   last_cyc = -1;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_v   = 1'b0;
        last_cyc = -1;
      end else begin
        if (pcm_valid) begin
          check("pcm_valid_width", 32'(prev_v), 32'd0);
          if (sb.size() == 0) begin
            check("unexpected_pcm_valid", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            if (e.chk) begin
              check("pcm_out", 32'(pcm_out), 32'(e.val));
              check("clip", 32'(clip), 32'(e.clp));
            end
          end
          if (chk_spacing && last_cyc >= 0) begin
            check("valid_spacing", 32'(cyc - last_cyc), 32'd256);
          end
          last_cyc = cyc;
        end else begin
          if (clip) check("clip_without_valid", 32'(clip), 32'd0);
        end
        prev_v = pcm_valid;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst    = 1'b0;
    pdm_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pcm_out", 32'(pcm_out), 32'd0);
    check("rst_pcm_valid", 32'(pcm_valid), 32'd0);
    check("rst_clip", 32'(clip), 32'd0);
    rst = 1'b1;
  endtask

  // Drives n_out*DECIM pdm_en pulses, one every en_per clocks, cycling a pattern.
  task automatic run_pcm(input logic [3:0] pat, input int plen, input int en_per, input int n_out);
    int bidx = 0;
    for (int c = 0; c < n_out * int'(DECIM) * en_per; c++) begin
      @(posedge clk);
      #1;
      pdm_en  = ((c % en_per) == en_per - 1);
      pdm_din = pat[bidx % plen];
      if (pdm_en) bidx++;
    end
    @(posedge clk);
    #1;
    pdm_en = 1'b0;
    repeat (10) @(posedge clk);
  endtask

  // DECIM pulses of din=1, then edge-by-edge latency check (tick edge = edge 1).
  task automatic latency(input bit abort);
    for (int i = 1; i <= int'(DECIM); i++) begin
      @(posedge clk);
      #1;
      if (i > 1 && !abort) check("early_pcm_valid", 32'(pcm_valid), 32'd0);
      pdm_en  = 1'b1;
      pdm_din = 1'b1;
    end
    @(posedge clk);
    #1;
    pdm_en = 1'b0;
    for (int k = 1; k <= int'(ORDER) + 3; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #1;
      end
      if (abort && k == 3) begin
        #1;
        rst = 1'b0;
        #1;
        check("async_rst_pcm_out", 32'(pcm_out), 32'd0);
        check("async_rst_valid", 32'(pcm_valid), 32'd0);
        check("async_rst_clip", 32'(clip), 32'd0);
        break;
      end
      check($sformatf("latency_edge%0d", k), 32'(pcm_valid), (k == int'(ORDER) + 2) ? 32'd1 : 32'd0);
    end
    if (abort) begin
      repeat (8) @(posedge clk);
      #1;
      rst = 1'b1;
    end
  endtask

  initial begin
    do_reset();

    // constant +1: clamps to full scale
    for (int i = 0; i < 4; i++) push(1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) push(1'b1, 16'h7fff, 1'b1);
    run_pcm(4'b0001, 1, 1, 8);

    do_reset();
    for (int i = 0; i < 4; i++) push(1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) push(1'b1, 16'h8000, 1'b0);
    run_pcm(4'b0000, 1, 1, 8);

    do_reset();
    for (int i = 0; i < 4; i++) push(1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) push(1'b1, 16'h0000, 1'b0);
    run_pcm(4'b0001, 2, 1, 8);

    do_reset();
    for (int i = 0; i < 4; i++) push(1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) push(1'b1, 16'h4000, 1'b0);
    run_pcm(4'b0111, 4, 1, 8);

    // reset in flight: pcm_out is 16384 here, pipe is discarded
    latency(1'b1);
    push(1'b0, '0, 1'b0);
    latency(1'b0);
    repeat (10) @(posedge clk);

    do_reset();
    push(1'b0, '0, 1'b0);
    latency(1'b0);
    repeat (10) @(posedge clk);

    // sparse pdm_en: same values, 256-clk cadence
    do_reset();
    chk_spacing = 1'b1;
    for (int i = 0; i < 4; i++) push(1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) push(1'b1, 16'h7fff, 1'b1);
    run_pcm(4'b0001, 1, 4, 8);
    chk_spacing = 1'b0;

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
